// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave front panel blocks.
package microwave_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCEPT,
      WAIT_RELEASE
   } kp_state_t;

   localparam int BCD_W     = 4;
   localparam int KEY_COUNT = 10;

endpackage

// File: rtl/key_prio_encoder.sv
// Combinational keypad encoder: lowest set line index, plus single-key and no-key flags.
module key_prio_encoder
   import microwave_pkg::*;
#(
   parameter int NUM_KEYS = KEY_COUNT
) (
   input  logic [NUM_KEYS-1:0] keys,
   output logic [BCD_W-1:0]    index,
   output logic                single,
   output logic                none
);

   localparam logic [NUM_KEYS-1:0] ONE = NUM_KEYS'(1);

   // Scan downward so the lowest set line wins.
   always_comb begin
      index = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (keys[i]) begin
            index = BCD_W'(i);
         end
      end
   end

   assign none   = (keys == '0);
   assign single = !none && ((keys & (keys - ONE)) == '0);

endmodule

// File: rtl/keypad_encoder.sv
// Keypad press encoder with one strobe per press and an mm:ss BCD entry buffer.
module keypad_encoder
   import microwave_pkg::*;
#(
   parameter int NUM_KEYS   = KEY_COUNT,
   parameter int NUM_DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_KEYS-1:0]       keys,
   input  logic                      key_stable,
   input  logic                      entry_en,
   input  logic                      entry_clr,
   output logic [3:0]                bcd,
   output logic                      key_pulse,
   output logic                      multi_err,
   output logic [4*NUM_DIGITS-1:0]   digits,
   output logic [2:0]                digit_count,
   output logic                      entry_full
);

   kp_state_t             state;
   logic [NUM_KEYS-1:0]   key_q;
   logic [BCD_W-1:0]      enc_index;
   logic                  enc_single;
   logic                  enc_none;
   logic                  shift_ok;

   key_prio_encoder #(
      .NUM_KEYS(NUM_KEYS)
   ) u_enc (
      .keys   (key_q),
      .index  (enc_index),
      .single (enc_single),
      .none   (enc_none)
   );

   assign entry_full = (digit_count == 3'(NUM_DIGITS));

   // Leading zeros and digits arriving on a full buffer are dropped silently.
   assign shift_ok = (state == ACCEPT) && enc_single && entry_en && !entry_full
                     && !((digit_count == 3'd0) && (enc_index == '0));

   // Press FSM: capture on key_stable, classify for one cycle, then wait for full release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         key_q     <= '0;
         bcd       <= '0;
         key_pulse <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         key_pulse <= 1'b0;
         multi_err <= 1'b0;
         case (state)
            IDLE: begin
               if (key_stable) begin
                  key_q <= keys;
                  state <= ACCEPT;
               end
            end
            ACCEPT: begin
               if (enc_single) begin
                  bcd       <= enc_index;
                  key_pulse <= 1'b1;
               end else if (!enc_none) begin
                  multi_err <= 1'b1;
               end
               state <= WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
               if (!key_stable && (keys == '0)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Entry buffer shifts left so the newest digit lands in the seconds-ones nibble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits      <= '0;
         digit_count <= '0;
      end else if (entry_clr) begin
         digits      <= '0;
         digit_count <= '0;
      end else if (shift_ok) begin
         digits      <= {digits[4*NUM_DIGITS-5:0], enc_index};
         digit_count <= digit_count + 3'd1;
      end
   end

endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboard bench for keypad_encoder: presses push expectations, a monitor checks each strobe.
module tb_keypad_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  keys;
   logic        key_stable;
   logic        entry_en;
   logic        entry_clr;
   logic [3:0]  bcd;
   logic        key_pulse;
   logic        multi_err;
   logic [15:0] digits;
   logic [2:0]  digit_count;
   logic        entry_full;

   typedef struct {
      int          cyc;
      logic        pulse;
      logic        multi;
      logic [3:0]  bcd;
      logic [15:0] digits;
      logic [2:0]  count;
      logic        full;
   } exp_t;

   exp_t expq[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   keypad_encoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .keys        (keys),
      .key_stable  (key_stable),
      .entry_en    (entry_en),
      .entry_clr   (entry_clr),
      .bcd         (bcd),
      .key_pulse   (key_pulse),
      .multi_err   (multi_err),
      .digits      (digits),
      .digit_count (digit_count),
      .entry_full  (entry_full)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pushExp(input int c, input logic multi, input logic [3:0] b,
                          input logic [15:0] d, input logic [2:0] n);
      exp_t e;
      e.cyc    = c;
      e.pulse  = !multi;
      e.multi  = multi;
      e.bcd    = b;
      e.digits = d;
      e.count  = n;
      e.full   = (n == 3'd4);
      expq.push_back(e);
   endtask

   // Press from IDLE; the strobe appears two edges after the capturing edge's negedge.
   task automatic applyStimulus(input logic [9:0] k, input int hold, input logic clr_at_accept,
                                input logic multi, input logic [3:0] b,
                                input logic [15:0] d, input logic [2:0] n);
      @(negedge clk);
      pushExp(cyc + 2, multi, b, d, n);
      keys       = k;
      key_stable = 1'b1;
      @(negedge clk);
      if (clr_at_accept) entry_clr = 1'b1;
      @(negedge clk);
      entry_clr = 1'b0;
      repeat (hold) @(negedge clk);
      keys       = '0;
      key_stable = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic clearBuffer();
      @(negedge clk);
      entry_clr = 1'b1;
      @(negedge clk);
      entry_clr = 1'b0;
      checkOutput("clr_digits", 32'(digits), 32'h0);
      checkOutput("clr_count", 32'(digit_count), 32'h0);
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && (key_pulse || multi_err)) begin
         if (expq.size() == 0) begin
            checkOutput("unexpected_strobe", {30'b0, key_pulse, multi_err}, 32'h0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            checkOutput("strobe_cycle", 32'(cyc), 32'(e.cyc));
            checkOutput("key_pulse", 32'(key_pulse), 32'(e.pulse));
            checkOutput("multi_err", 32'(multi_err), 32'(e.multi));
            checkOutput("bcd", 32'(bcd), 32'(e.bcd));
            checkOutput("digits", 32'(digits), 32'(e.digits));
            checkOutput("digit_count", 32'(digit_count), 32'(e.count));
            checkOutput("entry_full", 32'(entry_full), 32'(e.full));
         end
      end
   end

   initial begin
      repeat (5000) @(posedge clk);
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      keys       = 10'h010;
      key_stable = 1'b1;
      entry_en   = 1'b1;
      entry_clr  = 1'b0;

      // Reset held with a key already stable: everything idle, no strobe.
      repeat (3) @(negedge clk);
      checkOutput("rst_bcd", 32'(bcd), 32'h0);
      checkOutput("rst_pulse", 32'(key_pulse), 32'h0);
      checkOutput("rst_multi", 32'(multi_err), 32'h0);
      checkOutput("rst_digits", 32'(digits), 32'h0);
      checkOutput("rst_count", 32'(digit_count), 32'h0);
      checkOutput("rst_full", 32'(entry_full), 32'h0);
      pushExp(cyc + 2, 1'b0, 4'd4, 16'h0004, 3'd1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      keys       = '0;
      key_stable = 1'b0;
      repeat (3) @(negedge clk);
      clearBuffer();

      // Long single press of key 3.
      applyStimulus(10'h008, 10, 1'b0, 1'b0, 4'd3, 16'h0003, 3'd1);
      clearBuffer();

      // Fill to 12:30, then a fifth digit is dropped.
      applyStimulus(10'h002, 2, 1'b0, 1'b0, 4'd1, 16'h0001, 3'd1);
      applyStimulus(10'h004, 2, 1'b0, 1'b0, 4'd2, 16'h0012, 3'd2);
      applyStimulus(10'h008, 2, 1'b0, 1'b0, 4'd3, 16'h0123, 3'd3);
      applyStimulus(10'h001, 2, 1'b0, 1'b0, 4'd0, 16'h1230, 3'd4);
      applyStimulus(10'h020, 2, 1'b0, 1'b0, 4'd5, 16'h1230, 3'd4);

      // Two keys at once: error strobe, bcd and buffer untouched.
      applyStimulus(10'h00C, 2, 1'b0, 1'b1, 4'd5, 16'h1230, 3'd4);
      clearBuffer();

      // Leading zero dropped; clear beats a same-edge shift.
      applyStimulus(10'h001, 2, 1'b0, 1'b0, 4'd0, 16'h0000, 3'd0);
      applyStimulus(10'h100, 2, 1'b0, 1'b0, 4'd8, 16'h0008, 3'd1);
      applyStimulus(10'h200, 2, 1'b1, 1'b0, 4'd9, 16'h0000, 3'd0);

      // Entry disabled: strobe and bcd only.
      applyStimulus(10'h004, 2, 1'b0, 1'b0, 4'd2, 16'h0002, 3'd1);
      entry_en = 1'b0;
      applyStimulus(10'h080, 2, 1'b0, 1'b0, 4'd7, 16'h0002, 3'd1);
      entry_en = 1'b1;

      // Keys drop while key_stable stays high: still only one strobe.
      @(negedge clk);
      pushExp(cyc + 2, 1'b0, 4'd1, 16'h0021, 3'd2);
      keys       = 10'h002;
      key_stable = 1'b1;
      repeat (3) @(negedge clk);
      keys = '0;
      repeat (10) @(negedge clk);
      key_stable = 1'b0;
      repeat (3) @(negedge clk);

      applyStimulus(10'h040, 2, 1'b0, 1'b0, 4'd6, 16'h0216, 3'd3);

      repeat (3) @(negedge clk);
      checkOutput("pending_expectations", 32'(expq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
